// File: rtl/stream_selector_rr_pkg.sv
//------------------------------------------------------------------------------
// Module   : selector_pkg
// Brief    : Shared constants, lock FSM states and pointer helper for
//            stream_selector_rr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package selector_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Successor of idx in a ring of num channels.
  function automatic int unsigned ptr_incr(input int unsigned idx, input int unsigned num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_selector_rr_if.sv
//------------------------------------------------------------------------------
// Module   : stream_selector_rr_if
// Brief    : Multi-input valid/ready stream bundle and single output stream;
//            in_last/out_last exist only when SELECTOR_LOCK_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface stream_selector_rr_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
);

  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic                    mode;
  logic [SEL_W-1:0]        control_in;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;
`ifdef SELECTOR_LOCK_EN
  logic [NUM_IN-1:0]       in_last;
  logic                    out_last;
`endif

  modport master (
    output mode, control_in, in_valid, in_data, out_ready,
`ifdef SELECTOR_LOCK_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  mode, control_in, in_valid, in_data, out_ready,
`ifdef SELECTOR_LOCK_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

`default_nettype wire

// File: rtl/stream_selector_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Round-robin pointer register and rotate/priority-encode grant.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import selector_pkg::*;
#(
  parameter int NUM_IN = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_IN-1:0]                           req,
  input  logic                                        advance,
  input  logic [((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0] advance_idx,
  output logic [NUM_IN-1:0]                           grant
);

  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [NUM_IN-1:0] c_one = {{(NUM_IN-1){1'b0}}, 1'b1};

  logic [SEL_W-1:0]  r_ptr;
  logic [NUM_IN-1:0] w_mask;
  logic [NUM_IN-1:0] w_masked;
  logic [NUM_IN-1:0] w_pick;

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  always_comb begin
    w_mask   = ~((c_one << r_ptr) - c_one);
    w_masked = req & w_mask;
    w_pick   = (w_masked != '0) ? w_masked : req;
    grant    = w_pick & (~w_pick + c_one);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= SEL_W'(ptr_incr(32'(advance_idx), NUM_IN));
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_selector_rr.sv
//------------------------------------------------------------------------------
// Module   : stream_selector_rr
// Brief    : NUM_IN:1 valid/ready stream selector, fixed or round-robin, with a
//            registered output; SELECTOR_LOCK_EN adds packet locking.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_selector_rr
  import selector_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_selector_rr_if.slave  bus
);

  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0] w_rr_grant;
  logic [NUM_IN-1:0] w_fix_grant;
  logic [NUM_IN-1:0] w_grant;
  logic [NUM_IN-1:0] w_ready;
  logic              w_load;
  logic              w_hs;
  logic              w_adv;
  logic [SEL_W-1:0]  w_gidx;
  logic [WIDTH-1:0]  w_gdata;

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_sel;

  // Out-of-range control_in matches no loop index, so it grants nothing.
  always_comb begin
    w_fix_grant = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.control_in == SEL_W'(i)) begin
        w_fix_grant[i] = bus.in_valid[i];
      end
    end
  end

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.in_valid),
    .advance     (w_adv),
    .advance_idx (w_gidx),
    .grant       (w_rr_grant)
  );

`ifdef SELECTOR_LOCK_EN
  lock_state_t       r_state;
  lock_state_t       w_state_nxt;
  logic [SEL_W-1:0]  r_lock_ch;
  logic [NUM_IN-1:0] w_lock_grant;
  logic              w_last;
  logic              r_out_last;

  assign w_last = |(bus.in_last & w_grant);

  always_comb begin
    w_lock_grant = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_lock_ch == SEL_W'(i)) begin
        w_lock_grant[i] = bus.in_valid[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs && !w_last) w_state_nxt = LOCKED;
      LOCKED:  if (w_hs &&  w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lock_ch <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs && r_state == IDLE) begin
        r_lock_ch <= w_gidx;
      end
    end
  end

  always_comb begin
    if (r_state == LOCKED) begin
      w_grant = w_lock_grant;
    end else if (bus.mode == MODE_RR) begin
      w_grant = w_rr_grant;
    end else begin
      w_grant = w_fix_grant;
    end
  end

  // The pointer only moves once a whole packet has gone through.
  assign w_adv = w_hs & (bus.mode == MODE_RR) & w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_last <= 1'b0;
    end else if (w_hs) begin
      r_out_last <= w_last;
    end
  end

  assign bus.out_last = r_out_last;
`else
  assign w_grant = (bus.mode == MODE_RR) ? w_rr_grant : w_fix_grant;
  assign w_adv   = w_hs & (bus.mode == MODE_RR);
`endif

  always_comb begin
    w_gidx  = '0;
    w_gdata = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_grant[i]) begin
        w_gidx  = SEL_W'(i);
        w_gdata = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_load  = ~r_out_valid | bus.out_ready;
  assign w_ready = w_grant & {NUM_IN{w_load & ~rst}};
  assign w_hs    = |(bus.in_valid & w_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_hs) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gdata;
      r_out_sel   <= w_gidx;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_stream_selector_rr.sv
//------------------------------------------------------------------------------
// Module   : tb_stream_selector_rr
// Brief    : Directed bench for stream_selector_rr (lock steps under SELECTOR_LOCK_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stream_selector_rr;
  import selector_pkg::*;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [WIDTH-1:0] d [NUM_IN];

  stream_selector_rr_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

  stream_selector_rr #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int ch);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_sel"},   64'(bus.out_sel),   64'(ch));
    chk({tag, "_data"},  64'(bus.out_data),  64'(d[ch]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d[0] = 32'h1000_0001;
    d[1] = 32'h2000_0002;
    d[2] = 32'h3000_0003;
    d[3] = 32'h4000_0004;
    bus.in_data    = {d[3], d[2], d[1], d[0]};
    bus.mode       = MODE_RR;
    bus.control_in = '0;
    bus.in_valid   = 4'b1111;
    bus.out_ready  = 1'b1;
`ifdef SELECTOR_LOCK_EN
    bus.in_last    = 4'b1111;
`endif

    // Reset held with everything valid
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_out_sel",   64'(bus.out_sel),   64'd0);
    rst = 1'b0;
    #1;
    chk("first_grant", 64'(bus.in_ready), 64'b0001);

    // Round-robin, all valid, full throughput: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_beat("rr_all", k % 4);
    end

    // Reset mid-stream drops the held beat
    rst = 1'b1;
    bus.in_valid = 4'b0000;
    tick();
    chk("rst_drop_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;

    // Round-robin on sparse requests 1010 from pointer 0: 1,3,1
    bus.in_valid = 4'b1010;
    #1;
    chk("rr_sparse_rdy0", 64'(bus.in_ready), 64'b0010);
    tick();
    chk_beat("rr_sparse_b0", 1);
    chk("rr_sparse_rdy1", 64'(bus.in_ready), 64'b1000);
    tick();
    chk_beat("rr_sparse_b1", 3);
    chk("rr_sparse_rdy2", 64'(bus.in_ready), 64'b0010);
    tick();
    chk_beat("rr_sparse_b2", 1);

    // Backpressure: held beat stays stable, nothing accepted
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    #1;
    chk("bp_rdy_init", 64'(bus.in_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_beat("bp_hold", 1);
      chk("bp_rdy", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 64'(bus.in_ready), 64'b0100);
    tick();
    chk_beat("bp_release", 2);

    // Fixed mode on channel 2
    bus.mode       = MODE_FIXED;
    bus.control_in = 2'd2;
    #1;
    chk("fix_rdy", 64'(bus.in_ready), 64'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_beat("fix", 2);
    end
    bus.in_valid = 4'b1011;
    #1;
    chk("fix_ch_idle_rdy", 64'(bus.in_ready), 64'd0);

    // Back to round-robin: pointer stayed at 3 across fixed-mode beats
    bus.mode     = MODE_RR;
    bus.in_valid = 4'b1111;
    #1;
    chk("rr_ptr_frozen_rdy", 64'(bus.in_ready), 64'b1000);
    tick();
    chk_beat("rr_after_fix", 3);

`ifdef SELECTOR_LOCK_EN
    // Channel 1 sends a 3-beat packet while channel 2 is waiting
    rst = 1'b1;
    bus.in_valid = 4'b0000;
    tick();
    rst = 1'b0;
    bus.in_valid = 4'b0110;
    bus.in_last  = 4'b0000;
    tick();
    chk_beat("lock_b1", 1);
    chk("lock_b1_last", 64'(bus.out_last), 64'd0);
    chk("lock_rdy", 64'(bus.in_ready), 64'b0010);
    tick();
    chk_beat("lock_b2", 1);
    chk("lock_b2_last", 64'(bus.out_last), 64'd0);
    bus.in_last = 4'b0010;
    tick();
    chk_beat("lock_b3", 1);
    chk("lock_b3_last", 64'(bus.out_last), 64'd1);
    bus.in_valid = 4'b0100;
    bus.in_last  = 4'b0000;
    tick();
    chk_beat("lock_after", 2);
    chk("lock_after_last", 64'(bus.out_last), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
